t2mi_frame_scheduler: RTL and testbench

//  Sequences the T2-MI packet builder over each T2 frame.
//  Per frame it issues plp_num_blocks BB-frame packets, then one timestamp packet, then one L1 packet.
//  It owns every frame-level counter and hands the builder, at each packet start, the type, payload length and indices to use.
//  It sits between the TS sync/FIFO front end and the packet builder, and gates BB packets on FIFO fill.

---
 rtl/t2mi_frame_scheduler_if.sv | 25 ++
 rtl/t2mi_frame_scheduler.sv | 178 +++++++++++++++++
 tb/tb_t2mi_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t2mi_frame_scheduler_if.sv
// Packet-builder handshake between the T2 frame scheduler (master) and the T2-MI packet builder (slave).
interface t2mi_frame_scheduler_if;
    logic        PKT_START;
    logic [1:0]  PKT_TYPE;
    logic [15:0] PAYLOAD_LEN;
    logic [7:0]  PACKET_COUNT;
    logic [7:0]  FRAME_IDX;
    logic [3:0]  SUPERFRAME_IDX;
    logic [9:0]  BB_IDX;
    logic        INTL_START;
    logic [26:0] SUBSECONDS;
    logic        PKT_DONE;

    modport master (
        output PKT_START, PKT_TYPE, PAYLOAD_LEN, PACKET_COUNT, FRAME_IDX,
               SUPERFRAME_IDX, BB_IDX, INTL_START, SUBSECONDS,
        input  PKT_DONE
    );

    modport slave (
        input  PKT_START, PKT_TYPE, PAYLOAD_LEN, PACKET_COUNT, FRAME_IDX,
               SUPERFRAME_IDX, BB_IDX, INTL_START, SUBSECONDS,
        output PKT_DONE
    );
endinterface

// File: rtl/t2mi_frame_scheduler.sv
// Per-T2-frame packet sequencer: nblk BB-frame packets, one timestamp packet, one L1 packet,
// with BB packets gated on TS FIFO fill and a watchdog on the builder's completion pulse.
module t2mi_frame_scheduler #(
    parameter int L1_LEN_BYTES   = 62,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [15:0] k_bch,
    input  logic [9:0]  plp_num_blocks,
    input  logic [7:0]  num_t2_frames,
    input  logic [26:0] T_sf_ssu,
    input  logic [12:0] DATA_AVAIL,
    t2mi_frame_scheduler_if.master pkt,
    output logic        BUSY,
    output logic        ERR
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LATCH     = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_ADVANCE   = 3'd5;

    localparam logic [1:0] T_BB = 2'd0;
    localparam logic [1:0] T_TS = 2'd1;
    localparam logic [1:0] T_L1 = 2'd2;

    localparam logic [15:0] TS_BITS  = 16'd88;
    localparam logic [15:0] L1_BITS  = 16'((2 + L1_LEN_BYTES) * 8);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state, state_d;
    logic [12:0] kbch_q;
    logic [9:0]  nblk_q;
    logic [7:0]  nfr_q;
    logic [26:0] tsf_q;
    logic [15:0] tmo, tmo_d;
    logic [1:0]  ptype, type_d;
    logic [9:0]  bb_idx, bb_d;
    logic [7:0]  frame_idx, fr_d;
    logic [3:0]  sf_idx, sf_d;
    logic [26:0] subsec, sub_d;
    logic [7:0]  pcount, cnt_d;
    logic        err_q, err_d;
    logic [15:0] plen;
    logic        intl;

    logic [9:0]  nblk_m1;
    logic [7:0]  nfr_m1;
    logic [12:0] dfl_bytes;
    logic        unused_kbch_lsb;

    // Zero block/frame counts behave as one.
    assign nblk_m1   = (nblk_q == 10'd0) ? 10'd0 : nblk_q - 10'd1;
    assign nfr_m1    = (nfr_q == 8'd0) ? 8'd0 : nfr_q - 8'd1;
    assign dfl_bytes = kbch_q - 13'd10;
    assign unused_kbch_lsb = ^k_bch[2:0];

    function automatic logic [15:0] len_of(input logic [1:0] t, input logic [12:0] kb);
        case (t)
            T_BB:    len_of = {kb + 13'd3, 3'b000};
            T_TS:    len_of = TS_BITS;
            default: len_of = L1_BITS;
        endcase
    endfunction

    always_comb begin
        state_d = state;
        type_d  = ptype;
        bb_d    = bb_idx;
        fr_d    = frame_idx;
        sf_d    = sf_idx;
        sub_d   = subsec;
        cnt_d   = pcount;
        err_d   = err_q;
        tmo_d   = tmo;
        case (state)
            S_IDLE:      if (ENABLE && !err_q) state_d = S_LATCH;
            S_LATCH:     state_d = (ptype == T_BB) ? S_WAIT_DATA : S_ISSUE;
            S_WAIT_DATA: if (DATA_AVAIL >= dfl_bytes) state_d = S_ISSUE;
            S_ISSUE: begin
                tmo_d   = 16'd1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (pkt.PKT_DONE) begin
                    state_d = S_ADVANCE;
                end else if (tmo >= TMO_LAST) begin
                    // Builder hung: stop without advancing; only reset recovers.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo + 16'd1;
                end
            end
            S_ADVANCE: begin
                cnt_d = pcount + 8'd1;
                case (ptype)
                    T_BB: begin
                        if (bb_idx < nblk_m1) bb_d = bb_idx + 10'd1;
                        else                  type_d = T_TS;
                    end
                    T_TS: type_d = T_L1;
                    default: begin
                        type_d = T_BB;
                        bb_d   = 10'd0;
                        if (frame_idx < nfr_m1) begin
                            fr_d = frame_idx + 8'd1;
                        end else begin
                            fr_d  = 8'd0;
                            sf_d  = sf_idx + 4'd1;
                            sub_d = subsec + tsf_q;
                        end
                    end
                endcase
                if (!ENABLE)                           state_d = S_IDLE;
                else if (ptype == T_BB || ptype == T_TS) state_d = (type_d == T_BB) ? S_WAIT_DATA : S_ISSUE;
                else                                   state_d = S_LATCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            kbch_q    <= '0;
            nblk_q    <= '0;
            nfr_q     <= '0;
            tsf_q     <= '0;
            tmo       <= '0;
            ptype     <= T_BB;
            bb_idx    <= '0;
            frame_idx <= '0;
            sf_idx    <= '0;
            subsec    <= '0;
            pcount    <= '0;
            err_q     <= 1'b0;
            plen      <= '0;
            intl      <= 1'b0;
        end else begin
            state     <= state_d;
            tmo       <= tmo_d;
            ptype     <= type_d;
            bb_idx    <= bb_d;
            frame_idx <= fr_d;
            sf_idx    <= sf_d;
            subsec    <= sub_d;
            pcount    <= cnt_d;
            err_q     <= err_d;
            if (state == S_LATCH) begin
                kbch_q <= k_bch[15:3];
                nblk_q <= plp_num_blocks;
                nfr_q  <= num_t2_frames;
                tsf_q  <= T_sf_ssu;
            end
            // Packet descriptor is captured on entry to ISSUE and held until the next one.
            if (state_d == S_ISSUE) begin
                plen <= len_of(type_d, kbch_q);
                intl <= (type_d == T_BB) && (bb_d == 10'd0);
            end
        end
    end

    assign pkt.PKT_START      = (state == S_ISSUE);
    assign pkt.PKT_TYPE       = ptype;
    assign pkt.PAYLOAD_LEN    = plen;
    assign pkt.PACKET_COUNT   = pcount;
    assign pkt.FRAME_IDX      = frame_idx;
    assign pkt.SUPERFRAME_IDX = sf_idx;
    assign pkt.BB_IDX         = bb_idx;
    assign pkt.INTL_START     = intl;
    assign pkt.SUBSECONDS     = subsec;
    assign BUSY               = (state != S_IDLE);
    assign ERR                = err_q;
endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Bench for t2mi_frame_scheduler: closed-form packet-sequence model checked at every PKT_START,
// directed literal scenarios, then randomized config / FIFO fill / ENABLE / completion delay.
module tb_t2mi_frame_scheduler;
    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic [15:0] k_bch;
    logic [9:0]  plp_num_blocks;
    logic [7:0]  num_t2_frames;
    logic [26:0] T_sf_ssu;
    logic [12:0] DATA_AVAIL;
    logic        BUSY;
    logic        ERR;

    t2mi_frame_scheduler_if ifc();

    t2mi_frame_scheduler #(.L1_LEN_BYTES(62), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .k_bch(k_bch),
        .plp_num_blocks(plp_num_blocks), .num_t2_frames(num_t2_frames),
        .T_sf_ssu(T_sf_ssu), .DATA_AVAIL(DATA_AVAIL), .pkt(ifc),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    int n_pkt = 0;
    int c_nblk, c_nfr, c_kbch;
    longint c_tsf;
    logic [12:0] b_dfl;
    logic [12:0] prev_da;
    int  done_delay = 0;
    bit  rand_delay = 0;
    bit  stray_en = 0;
    logic [75:0] lg[$];
    int et10[10] = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
    int et6[6]   = '{0, 1, 2, 0, 1, 2};

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Field layout: type[75:74] bb[73:64] frame[63:56] sf[55:52] sub[51:25] cnt[24:17] intl[16] len[15:0]
    function automatic logic [75:0] dut_vec();
        return {ifc.PKT_TYPE, ifc.BB_IDX, ifc.FRAME_IDX, ifc.SUPERFRAME_IDX, ifc.SUBSECONDS,
                ifc.PACKET_COUNT, ifc.INTL_START, ifc.PAYLOAD_LEN};
    endfunction

    // Expected descriptor of the n-th packet since reset, from the frame structure alone.
    function automatic logic [75:0] model(int n);
        int nb, nf, per, ft, pos, sfc;
        logic [1:0] t;
        logic [9:0] bb;
        logic [15:0] pl;
        logic [26:0] sub;
        nb  = (c_nblk == 0) ? 1 : c_nblk;
        nf  = (c_nfr == 0) ? 1 : c_nfr;
        per = nb + 2;
        ft  = n / per;
        pos = n % per;
        sfc = ft / nf;
        t   = (pos < nb) ? 2'd0 : (pos == nb) ? 2'd1 : 2'd2;
        bb  = 10'((pos < nb) ? pos : nb - 1);
        sub = 27'(longint'(sfc) * c_tsf);
        pl  = (t == 2'd0) ? 16'((3 + (c_kbch >> 3)) * 8) : (t == 2'd1) ? 16'd88 : 16'd512;
        return {t, bb, 8'(ft % nf), 4'(sfc % 16), sub, 8'(n % 256), pos == 0, pl};
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            n_pkt <= 0;
            lg.delete();
        end else if (ifc.PKT_START) begin
            check("pkt_fields", dut_vec(), model(n_pkt));
            if (ifc.PKT_TYPE == 2'd0) check("bb_data_gate", prev_da >= b_dfl, 1'b1);
            lg.push_back(dut_vec());
            n_pkt <= n_pkt + 1;
        end
        prev_da <= DATA_AVAIL;
    end

    // Builder stand-in: optional ignored pulse in the ISSUE cycle, real PKT_DONE d cycles later.
    initial begin
        int d;
        ifc.PKT_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (ifc.PKT_START && done_delay > 0) begin
                d = rand_delay ? int'($urandom_range(1, 12)) : done_delay;
                ifc.PKT_DONE = stray_en && ($urandom % 2 == 0);
                repeat (d) @(negedge CLK) ifc.PKT_DONE = 1'b0;
                ifc.PKT_DONE = 1'b1;
                @(negedge CLK) ifc.PKT_DONE = 1'b0;
            end
        end
    end

    task automatic set_cfg(int nb, int nf, longint tsf, int kb);
        c_nblk = nb; c_nfr = nf; c_tsf = tsf; c_kbch = kb;
        plp_num_blocks = 10'(nb);
        num_t2_frames  = 8'(nf);
        T_sf_ssu       = 27'(tsf);
        k_bch          = 16'(kb);
        b_dfl          = 13'((kb >> 3) - 10);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; ENABLE = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (16) @(posedge CLK);
        #1;
    endtask

    task automatic wait_logs(int cnt, int lim, string nm);
        int c = 0;
        while (lg.size() < cnt && c < lim) begin
            @(negedge CLK); #1;
            c++;
        end
        check(nm, lg.size() >= cnt, 1'b1);
    endtask

    task automatic stop_and_idle(string nm);
        int c = 0;
        @(posedge CLK); #1;
        ENABLE = 1'b0;
        DATA_AVAIL = 13'd8191;
        while (BUSY && c < 200) begin
            @(negedge CLK);
            c++;
        end
        check(nm, BUSY, 1'b0);
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b0; DATA_AVAIL = '0;
        set_cfg(0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {ifc.PKT_START, dut_vec(), BUSY, ERR}, '0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // nblk=3 nfr=2, ample data, done 5 cycles after start
        do_reset();
        set_cfg(3, 2, 12345, 7032);
        DATA_AVAIL = 13'd8191; done_delay = 5; rand_delay = 0; stray_en = 0;
        ENABLE = 1'b1;
        wait_logs(10, 400, "seq10_started");
        stop_and_idle("seq10_idle");
        for (int i = 0; i < 10 && i < lg.size(); i++) begin
            check("seq_type", lg[i][75:74], et10[i]);
            check("seq_count", lg[i][24:17], i);
            check("seq_frame", lg[i][63:56], (i >= 5));
            check("seq_intl", lg[i][16], (i == 0 || i == 5));
        end
        if (lg.size() >= 5) begin
            check("bb_len", lg[0][15:0], 7056);
            check("ts_len", lg[3][15:0], 88);
            check("l1_len", lg[4][15:0], 512);
        end
        check("end_frame_idx", ifc.FRAME_IDX, 0);
        check("end_sf_idx", ifc.SUPERFRAME_IDX, 1);
        check("end_subseconds", ifc.SUBSECONDS, 12345);
        check("end_packet_count", ifc.PACKET_COUNT, 10);

        // FIFO fill threshold: 868 holds, 869 starts one cycle later
        do_reset();
        set_cfg(3, 2, 777, 7032);
        done_delay = 3;
        DATA_AVAIL = 13'd868;
        ENABLE = 1'b1;
        repeat (12) @(negedge CLK);
        check("no_start_at_868", lg.size(), 0);
        @(posedge CLK); #1;
        DATA_AVAIL = 13'd869;
        @(negedge CLK);
        check("start_not_early", ifc.PKT_START, 1'b0);
        @(negedge CLK);
        check("start_after_869", ifc.PKT_START, 1'b1);
        check("payload_7056", ifc.PAYLOAD_LEN, 7056);
        check("intl_first_bb", ifc.INTL_START, 1'b1);
        stop_and_idle("thresh_idle");

        // ENABLE dropped during the 2nd BB packet
        do_reset();
        set_cfg(3, 2, 500, 2000);
        DATA_AVAIL = 13'd8191; done_delay = 6;
        ENABLE = 1'b1;
        wait_logs(2, 200, "drop_second_bb");
        stop_and_idle("drop_idle");
        check("drop_bb_idx", ifc.BB_IDX, 2);
        check("drop_count", ifc.PACKET_COUNT, 2);
        @(posedge CLK); #1;
        ENABLE = 1'b1;
        wait_logs(3, 200, "resume_start");
        if (lg.size() >= 3) check("resume_bb_idx", lg[2][73:64], 2);
        stop_and_idle("resume_idle");

        // nblk=0 and nfr=0 behave as 1
        do_reset();
        set_cfg(0, 0, 1000, 1600);
        DATA_AVAIL = 13'd8191; done_delay = 2;
        ENABLE = 1'b1;
        wait_logs(6, 300, "zero_cfg_started");
        stop_and_idle("zero_cfg_idle");
        for (int i = 0; i < 6 && i < lg.size(); i++) check("zero_cfg_type", lg[i][75:74], et6[i]);
        if (lg.size() >= 4) begin
            check("zero_cfg_sf", lg[3][55:52], 1);
            check("zero_cfg_sub", lg[3][51:25], 1000);
            check("zero_cfg_intl", lg[3][16], 1'b1);
        end
        check("zero_cfg_end_sf", ifc.SUPERFRAME_IDX, 2);

        // PACKET_COUNT wrap
        do_reset();
        set_cfg(4, 3, 3, 800);
        DATA_AVAIL = 13'd8191; done_delay = 1;
        ENABLE = 1'b1;
        wait_logs(258, 4000, "wrap_started");
        stop_and_idle("wrap_idle");
        if (lg.size() >= 257) begin
            check("wrap_255", lg[255][24:17], 255);
            check("wrap_0", lg[256][24:17], 0);
        end

        // Timeout with PKT_DONE withheld
        do_reset();
        set_cfg(3, 2, 9, 2000);
        DATA_AVAIL = 13'd8191; done_delay = 0;
        ENABLE = 1'b1;
        wait_logs(1, 100, "tmo_start");
        repeat (15) @(negedge CLK);
        check("tmo_not_early", ERR, 1'b0);
        @(negedge CLK);
        check("tmo_err", ERR, 1'b1);
        check("tmo_busy", BUSY, 1'b0);
        repeat (40) @(negedge CLK);
        check("tmo_no_restart", lg.size(), 1);
        do_reset();
        check("tmo_cleared", ERR, 1'b0);

        // Synchronous reset during WAIT_DONE
        set_cfg(2, 1, 77, 2000);
        done_delay = 0;
        ENABLE = 1'b1;
        wait_logs(1, 100, "rst_mid_start");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_mid_packet", {ifc.PKT_START, dut_vec(), BUSY, ERR}, '0);
        @(posedge CLK); #1;
        RST = 1'b0; ENABLE = 1'b0;

        // Randomized phases
        for (int ph = 0; ph < 6; ph++) begin
            do_reset();
            set_cfg($urandom_range(0, 5), $urandom_range(0, 4), longint'($urandom % (1 << 27)),
                    $urandom_range(88, 65535));
            rand_delay = 1; stray_en = 1; done_delay = 1;
            ENABLE = 1'b1;
            repeat (400) begin
                @(posedge CLK); #1;
                if ($urandom % 4 == 0) DATA_AVAIL = (b_dfl == 0) ? 13'd0 : b_dfl - 13'd1;
                else DATA_AVAIL = (b_dfl > 13'd8188) ? 13'd8191 : b_dfl + 13'($urandom % 3);
                if ($urandom % 40 == 0) ENABLE = ~ENABLE;
            end
            stop_and_idle("rand_idle");
            check("rand_no_err", ERR, 1'b0);
            check("rand_progress", lg.size() >= 3, 1'b1);
        end
        rand_delay = 0; stray_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
